// File: rtl/reg_access_arbiter_pkg.sv
// Shared types and constants for the register access arbiter: class-select
// encoding, streak counter width and legal parameter ranges.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_WR   = 2'd1,
    CLS_RD   = 2'd2
  } cls_e;

  localparam int DATA_WIDTH_MIN = 8;
  localparam int DATA_WIDTH_MAX = 32;
  localparam int NUM_REQ_MIN    = 2;
  localparam int NUM_REQ_MAX    = 8;
  localparam int STREAK_MAX_LIM = 15;
  localparam int STREAK_W       = 4;

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Requester-side bus of the register access arbiter: per-requester request
// vectors in, registered grant and read response out.
interface reg_access_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic                          rvalid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         reg_q;

  modport master (
    output req, req_we, req_wdata,
    input  gnt, rvalid, rdata, rsp_id, reg_q
  );

  modport slave (
    input  req, req_we, req_wdata,
    output gnt, rvalid, rdata, rsp_id, reg_q
  );
endinterface

// File: rtl/reg_access_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of vec_i found
// searching upward from ptr_i+1, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] vec_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    idx_o
);

  localparam logic [ID_W:0] N_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0] cand_s;

  // Scan from the farthest offset down so the nearest hit after ptr wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand_s  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand_s  = {1'b0, ptr_i} + (ID_W+1)'(off);
      cand_s  = (cand_s >= N_W) ? (cand_s - N_W) : cand_s;
      valid_o = vec_i[cand_s[ID_W-1:0]] ? 1'b1 : valid_o;
      idx_o   = vec_i[cand_s[ID_W-1:0]] ? cand_s[ID_W-1:0] : idx_o;
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbitrates single-cycle read/write accesses from NUM_REQ requesters onto one
// storage register: writes beat reads, round-robin per class, write streak cap.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_REQ       = 4,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_access_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(MAX_WR_STREAK);
  localparam logic [ID_W-1:0]     PTR_RST    = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]  GNT_ONE    = NUM_REQ'(1);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
      NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX ||
      MAX_WR_STREAK < 1 || MAX_WR_STREAK > STREAK_MAX_LIM) begin : g_param_err
    $error("reg_access_arbiter: parameter out of legal range");
  end

  logic [NUM_REQ-1:0]    elig_s, wr_vec_s, rd_vec_s;
  logic                  wr_valid_s, rd_valid_s;
  logic [ID_W-1:0]       wr_idx_s, rd_idx_s;
  logic [DATA_WIDTH-1:0] wdata_s [NUM_REQ];
  cls_e                  cls_s;

  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;

  // The requester granted this cycle is masked so it cannot win the closing edge.
  assign elig_s   = bus.req & ~gnt_q;
  assign wr_vec_s = elig_s & bus.req_we;
  assign rd_vec_s = elig_s & ~bus.req_we;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_wdata
    assign wdata_s[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_wr_pick (
    .vec_i(wr_vec_s), .ptr_i(ptr_q), .valid_o(wr_valid_s), .idx_o(wr_idx_s)
  );

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rd_pick (
    .vec_i(rd_vec_s), .ptr_i(ptr_q), .valid_o(rd_valid_s), .idx_o(rd_idx_s)
  );

  // Class select: a full write streak yields to a pending read.
  always_comb begin
    cls_s = CLS_NONE;
    if (rd_valid_s && (streak_q == STREAK_CAP)) begin
      cls_s = CLS_RD;
    end else if (wr_valid_s) begin
      cls_s = CLS_WR;
    end else if (rd_valid_s) begin
      cls_s = CLS_RD;
    end else begin
      cls_s = CLS_NONE;
    end
  end

  // Grant, response, pointer and storage next state.
  always_comb begin
    gnt_d    = '0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rsp_id_d = rsp_id_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    case (cls_s)
      CLS_WR: begin
        gnt_d    = GNT_ONE << wr_idx_s;
        rsp_id_d = wr_idx_s;
        ptr_d    = wr_idx_s;
        data_d   = wdata_s[wr_idx_s];
      end
      CLS_RD: begin
        gnt_d    = GNT_ONE << rd_idx_s;
        rsp_id_d = rd_idx_s;
        ptr_d    = rd_idx_s;
        rdata_d  = data_q;
        rvalid_d = 1'b1;
      end
      default: begin
        gnt_d    = '0;
        rvalid_d = 1'b0;
      end
    endcase
  end

  // Consecutive write grants counted only while a read is waiting.
  always_comb begin
    streak_d = '0;
    if (!rd_valid_s) begin
      streak_d = '0;
    end else if (cls_s == CLS_WR) begin
      streak_d = (streak_q == STREAK_CAP) ? streak_q : (streak_q + STREAK_W'(1));
    end else begin
      streak_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rsp_id_q <= '0;
      data_q   <= '0;
      ptr_q    <= PTR_RST;
      streak_q <= '0;
    end else begin
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rsp_id_q <= rsp_id_d;
      data_q   <= data_d;
      ptr_q    <= ptr_d;
      streak_q <= streak_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.reg_q  = data_q;

endmodule
